// File: rtl/uart_pkg.sv
// Shared UART types and constants: feeder FSM state encoding and ASCII line-ending bytes.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CR_SEND,
        CR_WAIT
    } FeederState_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-facing bundle of the TX feeder. The slave modport is the feeder itself.
interface uart_tx_feeder_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  wr_data;
    logic        wr_en;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        overflow;
    logic [7:0]  tx_byte;
    logic        start_send;
    logic        done;
    logic        busy;

    modport master (
        output wr_data, wr_en, done,
        input  full, empty, level, overflow, tx_byte, start_send, busy
    );

    modport slave (
        input  wr_data, wr_en, done,
        output full, empty, level, overflow, tx_byte, start_send, busy
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered occupancy flags; writes while full and reads while empty are ignored.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       rd_en_i,
    output logic [7:0]                 rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q;
    logic          wr_ok, rd_ok;

    assign wr_ok = wr_en_i && !full_q;
    assign rd_ok = rd_en_i && !empty_q;

    always_comb begin
        level_d = level_q;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == FullLevel);
            empty_q <= (level_d == '0);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART transmitter (start/done).
// Define UART_TX_FEEDER_CRLF_EN to prefix every LF byte with a CR.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_baud,
    input  logic             rst,
    uart_tx_feeder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    FeederState_t state_q, state_d;
    logic [7:0]   tx_byte_q, tx_byte_d;
    logic         start_send_q, start_send_d;
    logic         overflow_q;
    logic         pop;
    logic [7:0]   head;
    logic         fifo_full, fifo_empty;
    logic [AW:0]  fifo_level;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i     (clk_baud),
        .rst_ni    (rst),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        start_send_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
`ifdef UART_TX_FEEDER_CRLF_EN
                    // LF stays queued until its CR has been acknowledged.
                    if (head == ASCII_LF) begin
                        tx_byte_d    = ASCII_CR;
                        start_send_d = 1'b1;
                        state_d      = CR_WAIT;
                    end else
`endif
                    begin
                        tx_byte_d    = head;
                        start_send_d = 1'b1;
                        pop          = 1'b1;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.done) state_d = IDLE;
            end
`ifdef UART_TX_FEEDER_CRLF_EN
            CR_WAIT: begin
                if (bus.done) state_d = CR_SEND;
            end
            CR_SEND: begin
                tx_byte_d    = head;
                start_send_d = 1'b1;
                pop          = 1'b1;
                state_d      = WAIT;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_baud) begin
        if (!rst) begin
            state_q      <= IDLE;
            tx_byte_q    <= 8'h00;
            start_send_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_byte_q    <= tx_byte_d;
            start_send_q <= start_send_d;
            // Uses the pre-edge full flag, so a same-cycle pop does not save the write.
            if (bus.wr_en && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign bus.full       = fifo_full;
    assign bus.empty      = fifo_empty;
    assign bus.level      = fifo_level;
    assign bus.overflow   = overflow_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.start_send = start_send_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder; the bench plays both producer and transmitter.
module tb_uart_tx_feeder;
    localparam int unsigned DEPTH = 16;

    logic clk_baud = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] sent_q[$];

    always #5 clk_baud = ~clk_baud;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk_baud (clk_baud),
        .rst      (rst),
        .bus      (bus)
    );

    // Record every byte handed to the transmitter (start_send lasts exactly one cycle).
    always @(negedge clk_baud) begin
        if (rst === 1'b1 && bus.start_send === 1'b1) sent_q.push_back(bus.tx_byte);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_baud);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.done    = 1'b0;
        bus.wr_data = 8'h00;
        tick();
        tick();
        rst = 1'b1;
        sent_q.delete();
    endtask

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_data = first + 8'(i);
            bus.wr_en   = 1'b1;
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.start_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hAA;
        bus.done    = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (bus.start_send !== 1'b0) begin n_err++; $display("FAIL reset_start got %b want 0", bus.start_send); end
        n_cmp++; if (bus.tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx_byte got %h want 00", bus.tx_byte); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        bus.wr_en = 1'b0;
        rst       = 1'b1;
        tick();
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_write_ignored empty got %b want 1", bus.empty); end
    endtask

    task automatic test_single_byte();
        do_reset();
        bus.wr_data = 8'h41;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.level !== 5'd1) begin n_err++; $display("FAIL single_level_after_write got %0d want 1", bus.level); end
        n_cmp++; if (bus.start_send !== 1'b0) begin n_err++; $display("FAIL single_start_early got %b want 0", bus.start_send); end
        tick();
        n_cmp++; if (bus.start_send !== 1'b1) begin n_err++; $display("FAIL single_start got %b want 1", bus.start_send); end
        n_cmp++; if (bus.tx_byte !== 8'h41) begin n_err++; $display("FAIL single_tx_byte got %h want 41", bus.tx_byte); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", bus.busy); end
        n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL single_level_pop got %0d want 0", bus.level); end
        tick();
        n_cmp++; if (bus.start_send !== 1'b0) begin n_err++; $display("FAIL single_start_width got %b want 0", bus.start_send); end
        n_cmp++; if (bus.tx_byte !== 8'h41) begin n_err++; $display("FAIL single_tx_hold got %h want 41", bus.tx_byte); end
        pulse_done();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_drop got %b want 0", bus.busy); end
        n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL single_level_end got %0d want 0", bus.level); end
        repeat (4) tick();
        n_cmp++; if (sent_q.size() != 1) begin n_err++; $display("FAIL single_count got %0d want 1", sent_q.size()); end
    endtask

    task automatic test_burst();
        bit ok;
        int bad;
        do_reset();
        write_bytes(8'h2F, 1);
        wait_start(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_first_start got timeout want start_send"); end
        write_bytes(8'h30, 16);
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL burst_full got %b want 1", bus.full); end
        n_cmp++; if (bus.level !== 5'd16) begin n_err++; $display("FAIL burst_level_full got %0d want 16", bus.level); end
        for (int k = 1; k <= 16; k++) begin
            pulse_done();
            wait_start(ok);
            n_cmp++;
            if (!ok || bus.tx_byte !== 8'h2F + 8'(k) || bus.level !== 5'(16 - k)) begin
                n_err++;
                $display("FAIL burst_pop_%0d got ok=%0d byte=%h level=%0d want byte=%h level=%0d",
                         k, ok, bus.tx_byte, bus.level, 8'h2F + 8'(k), 16 - k);
            end
            if (k == 1) begin
                n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL burst_full_clear got %b want 0", bus.full); end
            end
        end
        pulse_done();
        tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL burst_end got busy=%b empty=%b want 0 1", bus.busy, bus.empty); end
        bad = 0;
        for (int i = 0; i < sent_q.size(); i++) if (sent_q[i] !== 8'h2F + 8'(i)) bad++;
        n_cmp++; if (sent_q.size() != 17 || bad != 0) begin n_err++; $display("FAIL burst_order got count=%0d bad=%0d want count=17 bad=0", sent_q.size(), bad); end
    endtask

    task automatic test_overflow();
        bit ok;
        int bad;
        do_reset();
        write_bytes(8'hA0, 1);
        wait_start(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_first_start got timeout want start_send"); end
        write_bytes(8'hB0, 17);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        n_cmp++; if (bus.level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d want 16", bus.level); end
        repeat (3) tick();
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
        for (int k = 0; k < 16; k++) begin
            pulse_done();
            wait_start(ok);
            n_cmp++;
            if (!ok || bus.tx_byte !== 8'hB0 + 8'(k)) begin
                n_err++;
                $display("FAIL ovf_drain_%0d got ok=%0d byte=%h want %h", k, ok, bus.tx_byte, 8'hB0 + 8'(k));
            end
        end
        pulse_done();
        repeat (6) tick();
        bad = 0;
        for (int i = 0; i < sent_q.size(); i++) if (sent_q[i] === 8'hC0) bad++;
        n_cmp++; if (sent_q.size() != 17 || bad != 0) begin n_err++; $display("FAIL ovf_dropped_byte got count=%0d c0_seen=%0d want 17 0", sent_q.size(), bad); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after_drain got %b want 1", bus.overflow); end
        do_reset();
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_reset_clear got %b want 0", bus.overflow); end
    endtask

    task automatic test_wrap_simultaneous();
        bit ok;
        int bad;
        do_reset();
        write_bytes(8'h60, 1);
        wait_start(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_first_start got timeout want start_send"); end
        write_bytes(8'h61, 14);
        n_cmp++; if (bus.level !== 5'd14) begin n_err++; $display("FAIL wrap_level_fill got %0d want 14", bus.level); end
        for (int r = 0; r < 3; r++) begin
            bus.done = 1'b1;
            tick();
            bus.done    = 1'b0;
            bus.wr_data = 8'h6F + 8'(r);
            bus.wr_en   = 1'b1;
            tick();
            bus.wr_en = 1'b0;
            n_cmp++;
            if (bus.level !== 5'd14 || bus.start_send !== 1'b1 || bus.tx_byte !== 8'h61 + 8'(r)) begin
                n_err++;
                $display("FAIL wrap_round_%0d got level=%0d start=%b byte=%h want 14 1 %h",
                         r, bus.level, bus.start_send, bus.tx_byte, 8'h61 + 8'(r));
            end
        end
        for (int k = 0; k < 14; k++) begin
            pulse_done();
            wait_start(ok);
            n_cmp++;
            if (!ok || bus.tx_byte !== 8'h64 + 8'(k)) begin
                n_err++;
                $display("FAIL wrap_drain_%0d got ok=%0d byte=%h want %h", k, ok, bus.tx_byte, 8'h64 + 8'(k));
            end
        end
        pulse_done();
        tick();
        bad = 0;
        for (int i = 0; i < sent_q.size(); i++) if (sent_q[i] !== 8'h60 + 8'(i)) bad++;
        n_cmp++; if (sent_q.size() != 18 || bad != 0) begin n_err++; $display("FAIL wrap_order got count=%0d bad=%0d want 18 0", sent_q.size(), bad); end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        do_reset();
        write_bytes(8'h80, 1);
        wait_start(ok);
        write_bytes(8'h81, 5);
        n_cmp++; if (!ok || bus.busy !== 1'b1 || bus.level !== 5'd5) begin n_err++; $display("FAIL midrst_setup got ok=%0d busy=%b level=%0d want 1 1 5", ok, bus.busy, bus.level); end
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hFF;
        tick();
        n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL midrst_level got %0d want 0", bus.level); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.start_send !== 1'b0) begin n_err++; $display("FAIL midrst_start got %b want 0", bus.start_send); end
        n_cmp++; if (bus.tx_byte !== 8'h00) begin n_err++; $display("FAIL midrst_tx_byte got %h want 00", bus.tx_byte); end
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        sent_q.delete();
        pulse_done();
        repeat (10) tick();
        n_cmp++; if (sent_q.size() != 0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL midrst_no_send got count=%0d empty=%b want 0 1", sent_q.size(), bus.empty); end
    endtask

    task automatic test_crlf();
        bit ok;
        int bad;
        int n_exp;
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h41;
`ifdef UART_TX_FEEDER_CRLF_EN
        exp_seq[1] = 8'h0D;
        exp_seq[2] = 8'h0A;
        n_exp      = 3;
`else
        exp_seq[1] = 8'h0A;
        exp_seq[2] = 8'h00;
        n_exp      = 2;
`endif
        do_reset();
        write_bytes(8'h41, 1);
        bus.wr_data = 8'h0A;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.start_send !== 1'b1 || bus.tx_byte !== 8'h41) begin n_err++; $display("FAIL crlf_first got start=%b byte=%h want 1 41", bus.start_send, bus.tx_byte); end
        for (int i = 1; i < n_exp; i++) begin
            pulse_done();
            wait_start(ok);
            n_cmp++;
            if (!ok || bus.tx_byte !== exp_seq[i]) begin
                n_err++;
                $display("FAIL crlf_byte_%0d got ok=%0d byte=%h want %h", i, ok, bus.tx_byte, exp_seq[i]);
            end
        end
        pulse_done();
        repeat (5) tick();
        bad = 0;
        for (int i = 0; i < sent_q.size() && i < 3; i++) if (sent_q[i] !== exp_seq[i]) bad++;
        n_cmp++; if (sent_q.size() != n_exp || bad != 0) begin n_err++; $display("FAIL crlf_sequence got count=%0d bad=%0d want %0d 0", sent_q.size(), bad, n_exp); end
        n_cmp++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL crlf_end got empty=%b busy=%b want 1 0", bus.empty, bus.busy); end
    endtask

    initial begin
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.done    = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap_simultaneous();
        test_reset_mid_transfer();
        test_crlf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
